// File: rtl/swerv_types.sv
// Shared types for the debug-trigger CSR block: decode-stage trigger packet,
// stored mcontrol fields, CSR addresses and tdata1 bit positions.
// Optional: SWERV_TRIG_TIMING_EN adds a stored timing bit to mcontrol_t.
package swerv_types;

    typedef struct packed {
        logic        select;
        logic        match;
        logic        store;
        logic        load;
        logic        execute;
        logic        m;
        logic [31:0] tdata2;
    } trigger_pkt_t;

    typedef struct packed {
        logic dmode;
        logic hit;
        logic select;
`ifdef SWERV_TRIG_TIMING_EN
        logic timing;
`endif
        logic action;
        logic chain;
        logic match;
        logic m;
        logic execute;
        logic store;
        logic load;
    } mcontrol_t;

    localparam logic [11:0] CSR_TSELECT = 12'h7A0;
    localparam logic [11:0] CSR_TDATA1  = 12'h7A1;
    localparam logic [11:0] CSR_TDATA2  = 12'h7A2;

    localparam int TD1_DMODE   = 27;
    localparam int TD1_HIT     = 20;
    localparam int TD1_SELECT  = 19;
    localparam int TD1_TIMING  = 18;
    localparam int TD1_ACTION  = 12;
    localparam int TD1_CHAIN   = 11;
    localparam int TD1_MATCH   = 7;
    localparam int TD1_M       = 6;
    localparam int TD1_EXECUTE = 2;
    localparam int TD1_STORE   = 1;
    localparam int TD1_LOAD    = 0;

endpackage

// File: rtl/dec_trig_chain.sv
// Chain qualification for one trigger pair: when chained, each trigger of
// the pair fires only if its partner matched on the same instruction.
module dec_trig_chain (
    input  logic [1:0] q_i,
    input  logic       chain_i,
    output logic [1:0] fire_o
);

    // Purely combinational pair qualification
    always_comb begin
        fire_o[0] = q_i[0] & (~chain_i | q_i[1]);
        fire_o[1] = q_i[1] & (~chain_i | q_i[0]);
    end

endmodule

// File: rtl/dec_trigger_csr.sv
// Debug-trigger CSR holder: tselect/tdata1/tdata2, decode-stage trigger
// packets, chain-qualified fire and hit recording.
// Optional: SWERV_TRIG_TIMING_EN adds a per-trigger timing bit that delays
// fire/hit/action by one extra cycle.
module dec_trigger_csr
    import swerv_types::*;
#(
    parameter int          NUM_TRIG    = 4,
    parameter logic [3:0]  TDATA1_TYPE = 4'd2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         dbg_mode,
    input  logic                         csr_wen,
    input  logic [11:0]                  csr_addr,
    input  logic [31:0]                  csr_wdata,
    output logic [31:0]                  csr_rdata,
    output logic                         csr_trig_hit,
    input  logic                         trig_match_valid,
    input  logic [NUM_TRIG-1:0]          trig_match,
    output trigger_pkt_t [NUM_TRIG-1:0]  trigger_pkt_any,
    output logic [NUM_TRIG-1:0]          trig_fire_r,
    output logic                         trig_action_dbg_r
);

    logic [1:0]          tsel_q, tsel_d;
    mcontrol_t           mc_q   [NUM_TRIG];
    mcontrol_t           mc_d   [NUM_TRIG];
    logic [31:0]         td2_q  [NUM_TRIG];
    logic [31:0]         td2_d  [NUM_TRIG];
    logic [NUM_TRIG-1:0] fire_q, fire_d;
    logic                act_q, act_d;

    logic [NUM_TRIG-1:0] q_vec, fire, hit_set, chain_v, action_v;
    logic                sel_locked, partner_locked;

    // Full tdata1 read view built from the stored fields
    function automatic logic [31:0] td1_view(input mcontrol_t mc);
        logic [31:0] v;
        v = '0;
        v[31:28]       = TDATA1_TYPE;
        v[26:21]       = 6'h1F;
        v[TD1_DMODE]   = mc.dmode;
        v[TD1_HIT]     = mc.hit;
        v[TD1_SELECT]  = mc.select;
`ifdef SWERV_TRIG_TIMING_EN
        v[TD1_TIMING]  = mc.timing;
`endif
        v[TD1_ACTION]  = mc.action;
        v[TD1_CHAIN]   = mc.chain;
        v[TD1_MATCH]   = mc.match;
        v[TD1_M]       = mc.m;
        v[TD1_EXECUTE] = mc.execute;
        v[TD1_STORE]   = mc.store;
        v[TD1_LOAD]    = mc.load;
        return v;
    endfunction

    assign q_vec = trig_match & {NUM_TRIG{trig_match_valid}};

    // Flatten per-trigger chain/action bits for the pair qualifiers
    always_comb begin
        for (int i = 0; i < NUM_TRIG; i++) begin
            chain_v[i]  = mc_q[i].chain;
            action_v[i] = mc_q[i].action;
        end
    end

    genvar gp;
    generate
        for (gp = 0; gp < NUM_TRIG / 2; gp++) begin : g_pair
            dec_trig_chain u_chain (
                .q_i     (q_vec[2*gp+1 -: 2]),
                .chain_i (chain_v[2*gp]),
                .fire_o  (fire[2*gp+1 -: 2])
            );
        end
    endgenerate

`ifdef SWERV_TRIG_TIMING_EN
    logic [NUM_TRIG-1:0] timing_v, pend_q;

    // Triggers with timing=1 wait in a second stage before taking effect
    always_comb begin
        for (int i = 0; i < NUM_TRIG; i++) timing_v[i] = mc_q[i].timing;
        hit_set = (fire & ~timing_v) | pend_q;
    end

    // Delayed-fire holding stage
    always_ff @(posedge clk) begin
        if (rst) pend_q <= '0;
        else     pend_q <= fire & timing_v;
    end
`else
    assign hit_set = fire;
`endif

    assign sel_locked     = mc_q[tsel_q].dmode & ~dbg_mode;
    assign partner_locked = mc_q[tsel_q | 2'd1].dmode & ~dbg_mode;

    // Next-state: CSR writes to the selected trigger, then hit recording
    always_comb begin
        tsel_d = tsel_q;
        for (int i = 0; i < NUM_TRIG; i++) begin
            mc_d[i]  = mc_q[i];
            td2_d[i] = td2_q[i];
        end
        if (csr_wen) begin
            case (csr_addr)
                CSR_TSELECT: tsel_d = csr_wdata[1:0];
                CSR_TDATA1: if (!sel_locked) begin
                    mc_d[tsel_q].dmode   = csr_wdata[TD1_DMODE] & dbg_mode;
                    mc_d[tsel_q].hit     = csr_wdata[TD1_HIT];
                    mc_d[tsel_q].select  = csr_wdata[TD1_SELECT];
`ifdef SWERV_TRIG_TIMING_EN
                    mc_d[tsel_q].timing  = csr_wdata[TD1_TIMING];
`endif
                    mc_d[tsel_q].action  = csr_wdata[TD1_ACTION];
                    // Only the even trigger of a pair owns the chain bit, and
                    // it cannot chain onto a locked debug-mode partner.
                    mc_d[tsel_q].chain   = csr_wdata[TD1_CHAIN] & ~tsel_q[0] & ~partner_locked;
                    mc_d[tsel_q].match   = csr_wdata[TD1_MATCH];
                    mc_d[tsel_q].m       = csr_wdata[TD1_M];
                    mc_d[tsel_q].execute = csr_wdata[TD1_EXECUTE];
                    mc_d[tsel_q].store   = csr_wdata[TD1_STORE];
                    mc_d[tsel_q].load    = csr_wdata[TD1_LOAD];
                end
                CSR_TDATA2: if (!sel_locked) td2_d[tsel_q] = csr_wdata;
                default: ;
            endcase
        end
        // A fire in the same cycle beats a CSR write clearing hit
        for (int i = 0; i < NUM_TRIG; i++)
            mc_d[i].hit = mc_d[i].hit | hit_set[i];
        fire_d = hit_set;
        act_d  = |(hit_set & action_v);
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            tsel_q <= '0;
            fire_q <= '0;
            act_q  <= 1'b0;
            for (int i = 0; i < NUM_TRIG; i++) begin
                mc_q[i]  <= '0;
                td2_q[i] <= '0;
            end
        end else begin
            tsel_q <= tsel_d;
            fire_q <= fire_d;
            act_q  <= act_d;
            for (int i = 0; i < NUM_TRIG; i++) begin
                mc_q[i]  <= mc_d[i];
                td2_q[i] <= td2_d[i];
            end
        end
    end

    assign trig_fire_r       = fire_q;
    assign trig_action_dbg_r = act_q;

    // CSR read mux, pre-edge values only
    always_comb begin
        csr_trig_hit = 1'b1;
        csr_rdata    = '0;
        case (csr_addr)
            CSR_TSELECT: csr_rdata = {30'b0, tsel_q};
            CSR_TDATA1:  csr_rdata = td1_view(mc_q[tsel_q]);
            CSR_TDATA2:  csr_rdata = td2_q[tsel_q];
            default:     csr_trig_hit = 1'b0;
        endcase
    end

    // Decode-stage packets; access types are suppressed in debug mode
    always_comb begin
        for (int i = 0; i < NUM_TRIG; i++) begin
            trigger_pkt_any[i].select  = mc_q[i].select;
            trigger_pkt_any[i].match   = mc_q[i].match;
            trigger_pkt_any[i].store   = mc_q[i].store   & ~dbg_mode;
            trigger_pkt_any[i].load    = mc_q[i].load    & ~dbg_mode;
            trigger_pkt_any[i].execute = mc_q[i].execute & ~dbg_mode;
            trigger_pkt_any[i].m       = mc_q[i].m;
            trigger_pkt_any[i].tdata2  = td2_q[i];
        end
    end

endmodule

// File: tb/tb_dec_trigger_csr.sv
// Randomized + directed bench for dec_trigger_csr with a behavioural model.
module tb_dec_trigger_csr;
    import swerv_types::*;

    logic               clk = 1'b0;
    logic               rst, dbg_mode, csr_wen, trig_match_valid;
    logic [11:0]        csr_addr;
    logic [31:0]        csr_wdata, csr_rdata;
    logic               csr_trig_hit, trig_action_dbg_r;
    logic [3:0]         trig_match, trig_fire_r;
    trigger_pkt_t [3:0] trigger_pkt_any;

    always #5 clk = ~clk;

    dec_trigger_csr #(.NUM_TRIG(4), .TDATA1_TYPE(4'd2)) dut (
        .clk(clk), .rst(rst), .dbg_mode(dbg_mode), .csr_wen(csr_wen),
        .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
        .csr_trig_hit(csr_trig_hit), .trig_match_valid(trig_match_valid),
        .trig_match(trig_match), .trigger_pkt_any(trigger_pkt_any),
        .trig_fire_r(trig_fire_r), .trig_action_dbg_r(trig_action_dbg_r)
    );

    int passed = 0, total = 0;

    // Model state: one bit vector per field, indexed by trigger
    logic [1:0]  m_tsel;
    logic [3:0]  m_dmode, m_hit, m_sel, m_act, m_chain, m_match, m_m, m_exe, m_st, m_ld;
    logic [31:0] m_td2 [4];
    logic [3:0]  m_fire;
    logic        m_adbg;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic logic [31:0] m_td1(input int t);
        return (32'd2 << 28) | (32'h1F << 21)
             | (32'(m_dmode[t]) << 27) | (32'(m_hit[t]) << 20) | (32'(m_sel[t]) << 19)
             | (32'(m_act[t]) << 12) | (32'(m_chain[t]) << 11) | (32'(m_match[t]) << 7)
             | (32'(m_m[t]) << 6) | (32'(m_exe[t]) << 2) | (32'(m_st[t]) << 1) | 32'(m_ld[t]);
    endfunction

    task automatic model_reset();
        m_tsel = 0; m_dmode = 0; m_hit = 0; m_sel = 0; m_act = 0; m_chain = 0;
        m_match = 0; m_m = 0; m_exe = 0; m_st = 0; m_ld = 0; m_fire = 0; m_adbg = 0;
        for (int i = 0; i < 4; i++) m_td2[i] = 0;
    endtask

    task automatic model_step();
        logic [3:0] q, f;
        int t;
        if (rst) begin model_reset(); return; end
        q = trig_match & {4{trig_match_valid}};
        for (int i = 0; i < 4; i++)
            f[i] = q[i] && (!m_chain[i & 2] || q[i ^ 1]);
        m_adbg = |(f & m_act);
        m_fire = f;
        t = int'(m_tsel);
        if (csr_wen) begin
            if (csr_addr == 12'h7A0) m_tsel = csr_wdata[1:0];
            else if (csr_addr == 12'h7A1 && !(m_dmode[t] && !dbg_mode)) begin
                m_dmode[t] = csr_wdata[27] && dbg_mode;
                m_hit[t] = csr_wdata[20]; m_sel[t] = csr_wdata[19]; m_act[t] = csr_wdata[12];
                m_chain[t] = (t % 2 == 0) && csr_wdata[11] && !(m_dmode[t+1] && !dbg_mode);
                m_match[t] = csr_wdata[7]; m_m[t] = csr_wdata[6];
                m_exe[t] = csr_wdata[2]; m_st[t] = csr_wdata[1]; m_ld[t] = csr_wdata[0];
            end else if (csr_addr == 12'h7A2 && !(m_dmode[t] && !dbg_mode))
                m_td2[t] = csr_wdata;
        end
        m_hit = m_hit | f;
    endtask

    task automatic compare();
        logic [31:0] er;
        logic eh;
        eh = (csr_addr == 12'h7A0) || (csr_addr == 12'h7A1) || (csr_addr == 12'h7A2);
        er = (csr_addr == 12'h7A0) ? {30'b0, m_tsel} :
             (csr_addr == 12'h7A1) ? m_td1(int'(m_tsel)) :
             (csr_addr == 12'h7A2) ? m_td2[m_tsel] : 32'h0;
        chk("csr_trig_hit", {31'b0, csr_trig_hit}, {31'b0, eh});
        chk("csr_rdata", csr_rdata, er);
        chk("trig_fire_r", {28'b0, trig_fire_r}, {28'b0, m_fire});
        chk("trig_action_dbg_r", {31'b0, trig_action_dbg_r}, {31'b0, m_adbg});
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("pkt%0d_flags", i),
                {26'b0, trigger_pkt_any[i].select, trigger_pkt_any[i].match,
                 trigger_pkt_any[i].store, trigger_pkt_any[i].load,
                 trigger_pkt_any[i].execute, trigger_pkt_any[i].m},
                {26'b0, m_sel[i], m_match[i], m_st[i] & !dbg_mode, m_ld[i] & !dbg_mode,
                 m_exe[i] & !dbg_mode, m_m[i]});
            chk($sformatf("pkt%0d_tdata2", i), trigger_pkt_any[i].tdata2, m_td2[i]);
        end
    endtask

    // One cycle: drive, check mid-cycle, clock edge, advance model
    task automatic cyc(input logic r, input logic d, input logic w, input logic [11:0] a,
                       input logic [31:0] wd, input logic v, input logic [3:0] tm);
        rst = r; dbg_mode = d; csr_wen = w; csr_addr = a; csr_wdata = wd;
        trig_match_valid = v; trig_match = tm;
        #4;
        compare();
        @(posedge clk);
        model_step();
        #1;
    endtask

    initial begin
        logic [11:0] addrs [4];
        addrs[0] = 12'h7A0; addrs[1] = 12'h7A1; addrs[2] = 12'h7A2; addrs[3] = 12'h300;
        model_reset();
        rst = 1; dbg_mode = 0; csr_wen = 0; csr_addr = 12'h7A1; csr_wdata = 0;
        trig_match_valid = 0; trig_match = 0;
        @(posedge clk); #1;
        cyc(1, 0, 0, 12'h7A1, 0, 0, 0);
        chk("lit_reset_tdata1", csr_rdata, 32'h23E0_0000);
        chk("lit_reset_fire", {28'b0, trig_fire_r}, 32'h0);
        chk("lit_reset_pkt2", {26'b0, trigger_pkt_any[2].execute, 5'b0} | trigger_pkt_any[2].tdata2, 32'h0);

        // Trigger 2 execute|m with an address
        cyc(0, 0, 1, 12'h7A0, 32'd2, 0, 0);
        cyc(0, 0, 1, 12'h7A2, 32'h8000_1000, 0, 0);
        cyc(0, 0, 1, 12'h7A1, 32'h44, 0, 0);
        chk("lit_pkt2_exe_m", {30'b0, trigger_pkt_any[2].execute, trigger_pkt_any[2].m}, 32'h3);
        chk("lit_pkt2_tdata2", trigger_pkt_any[2].tdata2, 32'h8000_1000);
        cyc(0, 0, 0, 12'h7A1, 0, 1, 4'b0100);
        chk("lit_fire_t2", {28'b0, trig_fire_r}, 32'h4);
        chk("lit_hit_t2", {31'b0, csr_rdata[20]}, 32'h1);

        // Chained pair 0/1
        cyc(0, 0, 1, 12'h7A0, 32'd0, 0, 0);
        cyc(0, 0, 1, 12'h7A1, 32'h804, 0, 0);
        cyc(0, 0, 1, 12'h7A0, 32'd1, 0, 0);
        cyc(0, 0, 1, 12'h7A1, 32'h4, 0, 0);
        cyc(0, 0, 0, 12'h7A1, 0, 1, 4'b0001);
        chk("lit_chain_single", {28'b0, trig_fire_r}, 32'h0);
        cyc(0, 0, 0, 12'h7A1, 0, 1, 4'b0011);
        chk("lit_chain_both", {28'b0, trig_fire_r}, 32'h3);
        chk("lit_chain_hit1", {31'b0, csr_rdata[20]}, 32'h1);

        // Same-cycle hit clear on trigger 1 vs fire: hit wins
        cyc(0, 0, 1, 12'h7A1, 32'h4, 1, 4'b0011);
        chk("lit_hit_wins", {31'b0, csr_rdata[20]}, 32'h1);

        // Action on trigger 0 raises debug action for one cycle
        cyc(0, 0, 1, 12'h7A0, 32'd0, 0, 0);
        cyc(0, 0, 1, 12'h7A1, 32'h1804, 0, 0);
        cyc(0, 0, 0, 12'h7A1, 0, 1, 4'b0011);
        chk("lit_action_on", {31'b0, trig_action_dbg_r}, 32'h1);
        cyc(0, 0, 0, 12'h7A1, 0, 0, 0);
        chk("lit_action_off", {31'b0, trig_action_dbg_r}, 32'h0);

        // dmode lock on trigger 3; tselect upper bits ignored (7 -> 3)
        cyc(0, 0, 1, 12'h7A0, 32'd7, 0, 0);
        cyc(0, 1, 1, 12'h7A1, 32'h0800_0004, 0, 0);
        cyc(0, 0, 1, 12'h7A1, 32'h0, 0, 0);
        chk("lit_dmode_locked", {31'b0, csr_rdata[27]}, 32'h1);
        // chain write on trigger 2 blocked by locked trigger 3
        cyc(0, 0, 1, 12'h7A0, 32'd2, 0, 0);
        cyc(0, 0, 1, 12'h7A1, 32'h804, 0, 0);
        chk("lit_chain_lock", {31'b0, csr_rdata[11]}, 32'h0);
        // dmode write outside debug to an unlocked trigger stores 0
        cyc(0, 0, 1, 12'h7A0, 32'd5, 0, 0);
        cyc(0, 0, 1, 12'h7A1, 32'h0800_0004, 0, 0);
        chk("lit_tsel_wrap", {31'b0, csr_rdata[27]}, 32'h0);
        cyc(0, 1, 0, 12'h7A1, 0, 0, 0);
        chk("lit_dbg_exe_off", {31'b0, trigger_pkt_any[1].execute}, 32'h0);

        // Random traffic with occasional mid-operation reset
        for (int n = 0; n < 600; n++) begin
            cyc($urandom_range(0, 39) == 0, $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)),
                addrs[$urandom_range(0, 3)], $urandom, $urandom_range(0, 3) != 0, 4'($urandom));
        end
        cyc(1, 0, 0, 12'h7A1, 0, 1, 4'hF);
        chk("lit_midreset_fire", {28'b0, trig_fire_r}, 32'h0);
        chk("lit_midreset_rdata", csr_rdata, 32'h23E0_0000);
        cyc(0, 0, 0, 12'h7A0, 0, 0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
